// File: rtl/tdc_edge_ctrl_if.sv
// -----------------------------------------------------------------------------
// tdc_edge_ctrl_if
// Bundles the command, edge-event and result handshake signals of the TDC
// measurement controller.
//   slave  : controller side (takes commands/events, drives the result)
//   master : sequencer/consumer side (drives commands/events, takes result)
// Signals:
//   iArm, iAbort       arm request / abort current measurement
//   iRise, iFall       one-cycle edge pulses from the edge detector
//   iReady             consumer ready for the result
//   oBusy, oValid      measuring / result available
//   oRiseTs, oFallTs   coarse timestamps of the rise and fall events
//   oWidth             oFallTs - oRiseTs (modulo 2^CNT_W)
//   oTimeout, oLost    window expired / extra rise seen while waiting for fall
// -----------------------------------------------------------------------------
interface tdc_edge_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             iArm;
    logic             iAbort;
    logic             iRise;
    logic             iFall;
    logic             iReady;
    logic             oBusy;
    logic             oValid;
    logic [CNT_W-1:0] oRiseTs;
    logic [CNT_W-1:0] oFallTs;
    logic [CNT_W-1:0] oWidth;
    logic             oTimeout;
    logic             oLost;

    modport slave (
        input  iArm, iAbort, iRise, iFall, iReady,
        output oBusy, oValid, oRiseTs, oFallTs, oWidth, oTimeout, oLost
    );

    modport master (
        output iArm, iAbort, iRise, iFall, iReady,
        input  oBusy, oValid, oRiseTs, oFallTs, oWidth, oTimeout, oLost
    );
endinterface

// File: rtl/tdc_edge_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_edge_ctrl
// Single-shot pulse measurement controller for the TDC edge detector. An arm
// request opens a window of TIMEOUT cycles and starts a coarse counter; the
// first rise and the following fall are timestamped, the pulse width is
// computed, and the result is offered over a valid/ready handshake.
// Ports:
//   iClk  system clock
//   iRst  asynchronous active-low reset
//   bus   tdc_edge_ctrl_if.slave (commands, edge events, result handshake)
// Notes:
//   - While idle, every result field reads 0; fields are cleared on any
//     return to idle and again when a new measurement is armed.
//   - A rise on the very last window cycle while still waiting for the first
//     rise cannot complete a pulse, so the timeout is taken and the rise is
//     not recorded.
//   - iAbort outranks everything, including an arm request while idle.
// -----------------------------------------------------------------------------
module tdc_edge_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                 iClk,
    input  logic                 iRst,
    tdc_edge_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARMED     = 2'd1,
        S_WAIT_FALL = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_rise_ts;
    logic [CNT_W-1:0] r_fall_ts;
    logic [CNT_W-1:0] r_width;
    logic             r_busy;
    logic             r_valid;
    logic             r_timeout;
    logic             r_lost;

    logic             w_last;
    logic             w_cap_rise;
    logic             w_cap_fall;
    logic             w_set_lost;
    logic             w_set_to;
    logic             w_next_busy;

    assign w_last      = (r_cnt == LAST_CNT);
    assign w_next_busy = (w_next == S_ARMED) || (w_next == S_WAIT_FALL);

    always_comb begin
        w_next     = r_state;
        w_cap_rise = 1'b0;
        w_cap_fall = 1'b0;
        w_set_lost = 1'b0;
        w_set_to   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.iArm && !bus.iAbort) begin
                    w_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.iAbort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    // No rise can complete a pulse on the last cycle.
                    w_set_to = 1'b1;
                    w_next   = S_DONE;
                end else if (bus.iRise) begin
                    // A simultaneous fall belongs to no pulse yet; dropped.
                    w_cap_rise = 1'b1;
                    w_next     = S_WAIT_FALL;
                end
            end
            S_WAIT_FALL: begin
                if (bus.iAbort) begin
                    w_next = S_IDLE;
                end else begin
                    w_set_lost = bus.iRise;
                    if (bus.iFall) begin
                        // Fall on the last cycle still completes the pulse.
                        w_cap_fall = 1'b1;
                        w_next     = S_DONE;
                    end else if (w_last) begin
                        w_set_to = 1'b1;
                        w_next   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.iAbort || bus.iReady) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rise_ts <= '0;
            r_fall_ts <= '0;
            r_width   <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_lost    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_next_busy;
            r_valid <= (w_next == S_DONE);
            if ((w_next == S_IDLE) || (r_state == S_IDLE)) begin
                // Clearing on the arm edge makes the counter read 0 in the
                // first armed cycle.
                r_cnt     <= '0;
                r_rise_ts <= '0;
                r_fall_ts <= '0;
                r_width   <= '0;
                r_timeout <= 1'b0;
                r_lost    <= 1'b0;
            end else begin
                if (w_next_busy) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (w_cap_rise) begin
                    r_rise_ts <= r_cnt;
                end
                if (w_cap_fall) begin
                    r_fall_ts <= r_cnt;
                    r_width   <= r_cnt - r_rise_ts;
                end
                if (w_set_lost) begin
                    r_lost <= 1'b1;
                end
                if (w_set_to) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign bus.oBusy    = r_busy;
    assign bus.oValid   = r_valid;
    assign bus.oRiseTs  = r_rise_ts;
    assign bus.oFallTs  = r_fall_ts;
    assign bus.oWidth   = r_width;
    assign bus.oTimeout = r_timeout;
    assign bus.oLost    = r_lost;

endmodule

// File: doc/tdc_edge_ctrl.md
Name: tdc_edge_ctrl

Overview:
Measurement controller that sequences the TDC edge detector for single-shot pulse measurements. After an arm command it opens a timed window and runs a coarse cycle counter. It timestamps the first rising-edge pulse and the following falling-edge pulse from the edge detector, then computes the pulse width. The result is presented to the readout/UART logic over a valid/ready handshake.

Parameters:
CNT_W, 16, width of coarse counter, timestamps and width result.
TIMEOUT, 1000, window length in iClk cycles; must be at most 2^CNT_W - 1.

Ports:
iClk  in  1  system clock.
iRst  in  1  asynchronous, active-low reset.
iArm  in  1  arm request, single-cycle pulse.
iAbort  in  1  abort the current measurement.
iRise  in  1  rising-edge pulse from edge detector (one cycle wide).
iFall  in  1  falling-edge pulse from edge detector (one cycle wide).
iReady  in  1  consumer ready for the result.
oBusy  out  1  high in ARMED and WAIT_FALL.
oValid  out  1  result available.
oRiseTs  out  CNT_W  coarse count at the rise event.
oFallTs  out  CNT_W  coarse count at the fall event.
oWidth  out  CNT_W  oFallTs - oRiseTs.
oTimeout  out  1  window expired before the measurement completed.
oLost  out  1  an extra rise arrived while waiting for the fall.

Behaviour:
- Reset (iRst=0, async): state IDLE. All outputs 0 and counter 0.
- Reset deasserts synchronously to iClk. Reset mid-measurement discards everything.
- States: IDLE, ARMED, WAIT_FALL, DONE. All outputs are registered.
- IDLE:
  - iArm=1 -> ARMED next cycle.
  - Counter cleared to 0; oRiseTs, oFallTs, oWidth, oTimeout and oLost cleared.
  - iRise and iFall ignored.
- Counter:
  - Value is 0 in the first ARMED cycle and increments by 1 each cycle in ARMED or WAIT_FALL.
  - An event sampled in a cycle where the counter = k is timestamped k.
- ARMED:
  - iRise=1 -> latch oRiseTs=counter, go to WAIT_FALL.
  - iFall alone is ignored, since a fall before any rise is not a pulse.
  - iRise and iFall in the same cycle -> the rise is accepted and the fall is ignored.
- WAIT_FALL:
  - iFall=1 -> latch oFallTs=counter and oWidth=counter-oRiseTs (modulo 2^CNT_W), go to DONE.
  - iRise=1 without iFall -> set oLost=1 (sticky until the next arm) and stay in WAIT_FALL.
  - iRise and iFall in the same cycle -> the fall is taken; oLost is set.
- Timeout:
  - In ARMED or WAIT_FALL, if the counter = TIMEOUT-1 and no completing event occurs that cycle -> oTimeout=1, go to DONE.
  - Fields not captured remain 0.
  - A completing event on the TIMEOUT-1 cycle wins over the timeout.
- DONE:
  - oValid=1 and all result outputs are held stable.
  - Transfer happens on oValid & iReady -> IDLE next cycle, oValid=0.
  - iArm in DONE is ignored; the result must be consumed first.
- Latency: oValid rises on the cycle after the iFall or timeout cycle.
- iAbort=1 in ARMED, WAIT_FALL or DONE -> IDLE next cycle, oValid=0, result dropped. iAbort has priority over all other inputs.
- oBusy=1 exactly in ARMED and WAIT_FALL.
- iArm while in ARMED or WAIT_FALL is ignored; the counter is not restarted.

Test Plan:
1. Reset with iRst=0 mid-stream -> all outputs 0 and state IDLE; iRise pulses are ignored until armed.
2. Arm, iRise at count 5, iFall at count 25, iReady=1 -> oValid one cycle after the fall with oRiseTs=5, oFallTs=25, oWidth=20, oTimeout=0; back to IDLE.
3. Arm, iFall at count 3, then iRise at 10 and iFall at 14 -> the first fall is ignored; oRiseTs=10, oWidth=4.
4. TIMEOUT=1000, arm, iRise at 100, no fall -> oTimeout=1, oRiseTs=100, oFallTs=0, oValid one cycle after count 999. A second run with iFall exactly at count 999 -> oTimeout=0, oFallTs=999.
5. Hold iReady=0 for 10 cycles in DONE while pulsing iArm and iRise -> outputs stay stable and no re-arm occurs; iReady=1 -> IDLE.
6. Rise at 2, extra rise at 6, fall at 9 -> oLost=1, oWidth=7. Separately, iAbort in WAIT_FALL -> IDLE and no oValid pulse.
